// File: rtl/blink_pkg.sv
// Shared types and default constants for the LED blink sequencer.
package blink_pkg;

    // Sequencer states; DONE lasts exactly one cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } blink_state_t;

    localparam int         BLINK_DIV_W          = 24;
    localparam int         BLINK_PAT_LEN        = 8;
    localparam int         BLINK_DEFAULT_DIV    = 25;
    localparam logic [7:0] BLINK_DEFAULT_PAT    = 8'hAA;
    localparam logic [3:0] BLINK_DEFAULT_REPEAT = 4'd1;

endpackage

// File: rtl/blink_tick_gen.sv
// Bit-period divider: counts 0..div-1 while enabled and flags the last count.
// A divider of 0 or 1 gives a tick on every enabled cycle.
module blink_tick_gen
    import blink_pkg::*;
#(
    parameter int DIV_W = BLINK_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (div <= DIV_W'(1)) || (r_cnt >= (div - DIV_W'(1)));
    assign tick   = en && w_last;

    // Counter is held at zero whenever disabled, so every run starts cleanly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/blink_seq_ctrl.sv
// LED pattern sequencer: shifts a latched bit pattern out on led, one bit per
// div clocks, for a configurable number of repetitions (0 = until stopped).
//
// Config handshake: a word transfers on a rising edge where cfg_valid && cfg_ready.
// cfg_ready is high only in IDLE; cfg_valid in any other state is ignored and
// the latched configuration is left untouched.
module blink_seq_ctrl
    import blink_pkg::*;
#(
    parameter int                   DIV_W       = BLINK_DIV_W,
    parameter int                   PAT_LEN     = BLINK_PAT_LEN,
    parameter int                   DEFAULT_DIV = BLINK_DEFAULT_DIV,
    parameter logic [PAT_LEN-1:0]   DEFAULT_PAT = BLINK_DEFAULT_PAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [3:0]         cfg_repeat,
    input  logic               start,
    input  logic               stop,
    output logic               led,
    output logic               busy,
    output logic               done,
    output blink_state_t       dbg_state
);

    localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    blink_state_t       r_state;
    blink_state_t       w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [3:0]         r_rep_cnt;
    logic [3:0]         w_rep_nxt;
    logic [3:0]         w_rep_inc;
    logic [PAT_LEN-1:0] r_pattern;
    logic [PAT_LEN-1:0] w_pat_use;
    logic [DIV_W-1:0]   r_div;
    logic [3:0]         r_repeat;
    logic               r_led;
    logic               r_busy;
    logic               r_done;
    logic               w_led_nxt;
    logic               w_xfer;
    logic               w_tick;

    assign cfg_ready = (r_state == ST_IDLE);
    assign led       = r_led;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

    blink_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (r_state == ST_RUN),
        .div   (r_div),
        .tick  (w_tick)
    );

    // Next state, bit index, repeat count and the LED value to register.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep_cnt;
        w_led_nxt   = 1'b0;
        w_xfer      = (r_state == ST_IDLE) && cfg_valid;
        // A config word arriving with start is used by that very run.
        w_pat_use   = w_xfer ? cfg_pattern : r_pattern;
        w_rep_inc   = (r_rep_cnt == 4'hF) ? 4'hF : (r_rep_cnt + 4'd1);
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = '0;
                    w_rep_nxt   = 4'd0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (r_idx == IDX_W'(PAT_LEN - 1)) begin
                        w_idx_nxt = '0;
                        w_rep_nxt = w_rep_inc;
                        if ((r_repeat != 4'd0) && (w_rep_inc == r_repeat)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_state_nxt == ST_RUN) begin
            w_led_nxt = w_pat_use[w_idx_nxt];
        end
    end

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_rep_cnt <= 4'd0;
            r_pattern <= DEFAULT_PAT;
            r_div     <= DIV_W'(DEFAULT_DIV);
            r_repeat  <= BLINK_DEFAULT_REPEAT;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_rep_cnt <= w_rep_nxt;
            if (w_xfer) begin
                r_pattern <= cfg_pattern;
                r_div     <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                r_repeat  <= cfg_repeat;
            end
            r_led     <= w_led_nxt;
            r_busy    <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

endmodule

// File: doc/blink_seq_ctrl.md
BLINK_SEQ_CTRL -- requirements
Module: blink_seq_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 24, width of the bit-period divider.
REQ-002 SHALL have parameter PAT_LEN, default 8, number of bits in one LED pattern.
REQ-003 SHALL have parameter DEFAULT_DIV, default 25, divider value loaded at reset.
REQ-004 SHALL have parameter DEFAULT_PAT, default 8'hAA, pattern value loaded at reset.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  one clock; reset is synchronous and active-low.
REQ-007 SHALL have port cfg_valid  input  1  configuration word offered.
REQ-008 SHALL have port cfg_ready  output  1  configuration can be accepted.
REQ-009 SHALL have port cfg_pattern  input  PAT_LEN  LED bit pattern, bit 0 shown first.
REQ-010 SHALL have port cfg_div  input  DIV_W  clocks per pattern bit.
REQ-011 SHALL have port cfg_repeat  input  4  pattern repetitions; 0 means repeat forever.
REQ-012 SHALL have port start  input  1  begin sequence (level sampled each cycle).
REQ-013 SHALL have port stop  input  1  abort sequence.
REQ-014 SHALL have port led  output  1  registered LED drive.
REQ-015 SHALL have port busy  output  1  high while in RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at normal completion.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL assert cfg_ready only in IDLE; a transfer occurs when cfg_valid && cfg_ready; the pattern, divider and repeat are latched on that edge.
REQ-019 SHALL ignore cfg_valid outside IDLE, with no change to the latched configuration.
REQ-020 SHALL treat a latched cfg_div of 0 as 1.
REQ-021 SHALL leave IDLE for RUN on the edge where start=1 and stop=0; on that same edge it SHALL clear bit_idx, the divide counter and the repeat counter.
REQ-022 SHALL use the newly latched configuration for the run when cfg_valid and start coincide in IDLE.
REQ-023 SHALL drive led = pattern[bit_idx] while in RUN, so that led = pattern[0] is visible one cycle after start is accepted.
REQ-024 SHALL have the divide counter count 0..div-1 in RUN and, on reaching div-1, wrap to 0 and advance bit_idx; each bit is therefore held exactly div cycles.
REQ-025 SHALL, when bit_idx wraps from PAT_LEN-1 to 0, increment the repeat counter; if cfg_repeat is nonzero and the count equals cfg_repeat, the FSM SHALL go to DONE instead.
REQ-026 SHALL, in DONE, hold led=0, pulse done for exactly one cycle, and return to IDLE on the next edge.
REQ-027 SHALL, when cfg_repeat=0, run until stop with the repeat counter saturating at 15.
REQ-028 SHALL, when stop=1 in RUN, go to IDLE on the next edge with led=0 and no done pulse.
REQ-029 SHALL give stop priority over start when both are asserted on the same edge.
REQ-030 SHALL hold led=0 and busy=0 in IDLE.
REQ-031 SHALL register every output; there is no combinational path from input to output except cfg_ready, which is decoded from state.

Reset
REQ-032 SHALL, when reset=0 at a clock edge, set the state to IDLE, led=0, busy=0, done=0, all counters to 0, pattern=DEFAULT_PAT, div=DEFAULT_DIV and repeat=1.
REQ-033 SHALL abort a run when reset is asserted mid-RUN, with no done pulse, and SHALL have cfg_ready=1 on the first edge after reset deasserts.

Structure
REQ-034 SHALL take the FSM state type, PAT_LEN and default constants from a shared package blink_pkg.
REQ-035 SHALL place the divide counter and its wrap tick in one sub-module blink_tick_gen (inputs clk, reset, en, div; output tick).

Verification
REQ-036 SHALL verify reset defaults: hold reset=0 for 2 cycles, then start -> led follows 8'hAA, toggling every 25 cycles, done after 200 cycles.
REQ-037 SHALL verify a configuration run: load pattern 8'h0F, div 3, repeat 2, then start -> led=1 for 12 cycles, 0 for 12 cycles, repeated twice, with done pulsing once at cycle 49 after start.
REQ-038 SHALL verify the handshake: with cfg_valid held during RUN, cfg_ready=0 and the configuration is unchanged; the transfer occurs on the first IDLE cycle.
REQ-039 SHALL verify stop and start asserted together in IDLE and mid-RUN -> FSM in IDLE, led=0, no done pulse.
REQ-040 SHALL verify div=0 with pattern 8'h01 and repeat 1 -> led=1 for 1 cycle, then 0 for 7 cycles, then done.
REQ-041 SHALL verify reset=0 mid-RUN with repeat=0 -> led=0 and busy=0 on the next edge, and cfg_ready=1 after release.
